prog_loader: RTL

- Writer end of program memory: receives a framed byte stream and writes 16-bit instruction words into the dual-port RAM write port (port a).
- Those are the words stage1 later fetches over port b.
- After a verified load it pulses the CPU reset input (posedge-triggered) to start execution.
- Sits between a host byte source (UART/debug bridge) and simple_dual_two_clocks port a.

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/prog_loader_if.sv | 27 ++
 rtl/loader_csum.sv | 34 +++
 rtl/prog_loader.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared program-memory geometry and loader frame-state encoding.
package prog_loader_pkg;

  // RAM geometry shared by stage1, the dual-port RAM and the loader.
  localparam int unsigned RamAddrW = 10;
  localparam int unsigned RamDataW = 16;

  typedef enum logic [3:0] {
    StIdle,
    StAddrHi,
    StAddrLo,
    StCntHi,
    StCntLo,
    StDataHi,
    StDataLo,
    StWrite,
    StCsum,
    StStart,
    StDone,
    StError
  } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and RAM write-port bundle of the program loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = prog_loader_pkg::RamAddrW
);
  import prog_loader_pkg::*;

  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic                ena;
  logic                wea;
  logic [ADDR_W-1:0]   addra;
  logic [RamDataW-1:0] dia;

  // master: the loader (consumes bytes, drives RAM port a)
  modport master (
    input  in_valid, in_data,
    output in_ready, ena, wea, addra, dia
  );

  // slave: host byte source plus RAM port a
  modport slave (
    output in_valid, in_data,
    input  in_ready, ena, wea, addra, dia
  );

endinterface

// File: rtl/loader_csum.sv
// 8-bit XOR frame checksum: clear, accumulate, and compare against the incoming byte.
module loader_csum (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       accum_i,
  input  logic [7:0] data_i,
  output logic       match_o
);

  logic [7:0] sum_q, sum_d;

  // Clear wins over accumulate so a new load starts from zero.
  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (accum_i) begin
      sum_d = sum_q ^ data_i;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match_o = (data_i == sum_q);

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses a framed byte stream, writes 16-bit words to RAM port a,
// and pulses the CPU reset after a frame with a good checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = RamAddrW,
  parameter int unsigned CPU_RST_CYCLES = 1
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start_i,
  prog_loader_if.master     bus,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W:0]   words_written_o
);

  localparam int unsigned MaxWords = 1 << ADDR_W;
  localparam int unsigned RstCntW  = (CPU_RST_CYCLES > 1) ? $clog2(CPU_RST_CYCLES) : 1;
  localparam logic [RstCntW-1:0] RstLast = RstCntW'(CPU_RST_CYCLES - 1);
  localparam logic [ADDR_W:0]    CntOne  = 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     ww_q, ww_d;
  logic [7:0]          hi_q, hi_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [RamDataW-1:0] dia_q, dia_d;
  logic [RstCntW-1:0]  rcnt_q, rcnt_d;

  logic        in_ready;
  logic        accept;
  logic [15:0] word16;
  logic        addr_oob;
  logic        cnt_oob;
  logic        csum_clear;
  logic        csum_accum;
  logic        csum_match;

  assign in_ready = state_q inside {StAddrHi, StAddrLo, StCntHi, StCntLo,
                                    StDataHi, StDataLo, StCsum};
  assign accept   = bus.in_valid & in_ready;
  // Big-endian pair: buffered high byte plus the byte on the bus now.
  assign word16   = {hi_q, bus.in_data};
  assign addr_oob = (32'(word16) >> ADDR_W) != 32'd0;
  assign cnt_oob  = 32'(word16) > MaxWords;
  // The CSUM byte itself is compared, never accumulated.
  assign csum_accum = accept & (state_q != StCsum);

  loader_csum u_csum (
    .clk_i   (clka),
    .rst_ni  (rst),
    .clear_i (csum_clear),
    .accum_i (csum_accum),
    .data_i  (bus.in_data),
    .match_o (csum_match)
  );

  // Frame parser next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    ww_d       = ww_q;
    hi_d       = hi_q;
    addra_d    = addra_q;
    dia_d      = dia_q;
    rcnt_d     = rcnt_q;
    csum_clear = 1'b0;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          ww_d       = '0;
          csum_clear = 1'b1;
          state_d    = StAddrHi;
        end
      end
      StAddrHi, StCntHi, StDataHi: begin
        if (accept) begin
          hi_d = bus.in_data;
          unique case (state_q)
            StAddrHi: state_d = StAddrLo;
            StCntHi:  state_d = StCntLo;
            default:  state_d = StDataLo;
          endcase
        end
      end
      StAddrLo: begin
        if (accept) begin
          if (addr_oob) begin
            state_d = StError;
          end else begin
            addr_d  = word16[ADDR_W-1:0];
            state_d = StCntHi;
          end
        end
      end
      StCntLo: begin
        if (accept) begin
          if (cnt_oob) begin
            state_d = StError;
          end else if (word16 == 16'd0) begin
            state_d = StCsum;
          end else begin
            cnt_d   = word16[ADDR_W:0];
            state_d = StDataHi;
          end
        end
      end
      StDataLo: begin
        if (accept) begin
          dia_d   = word16;
          addra_d = addr_q;
          state_d = StWrite;
        end
      end
      StWrite: begin
        // Address wraps naturally at 2**ADDR_W.
        addr_d  = addr_q + 1'b1;
        ww_d    = ww_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CntOne) ? StCsum : StDataHi;
      end
      StCsum: begin
        if (accept) begin
          if (csum_match) begin
            rcnt_d  = '0;
            state_d = StStart;
          end else begin
            state_d = StError;
          end
        end
      end
      StStart: begin
        if (rcnt_q == RstLast) begin
          state_d = StDone;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any load in progress.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      ww_q    <= '0;
      hi_q    <= '0;
      addra_q <= '0;
      dia_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ww_q    <= ww_d;
      hi_q    <= hi_d;
      addra_q <= addra_d;
      dia_q   <= dia_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.ena         = (state_q == StWrite);
  assign bus.wea         = (state_q == StWrite);
  assign bus.addra       = addra_q;
  assign bus.dia         = dia_q;
  assign cpu_rst_o       = (state_q == StStart);
  assign done_o          = (state_q == StDone);
  assign error_o         = (state_q == StError);
  assign busy_o          = !(state_q inside {StIdle, StDone, StError});
  assign words_written_o = ww_q;

endmodule
